// File: rtl/uart_defs.sv
//------------------------------------------------------------------------------
// uart_defs : shared types and helpers for the UART TX arbitration path
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } txState_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS_DEFAULT = 11;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
//------------------------------------------------------------------------------
// uart_rr_pick : combinational rotate-priority pick starting at the rr pointer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rr_pick
    import uart_defs::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_rrPtr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grantIdx,
    output logic               o_valid
);

    always_comb begin
        logic [ID_W-1:0] w_idx;
        w_idx      = '0;
        o_grant    = '0;
        o_grantIdx = '0;
        o_valid    = 1'b0;
        // First set bit at or above the pointer, wrapping past the top index
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = ID_W'((int'(i_rrPtr) + i) % NUM_REQ);
            if (!o_valid && i_req[w_idx]) begin
                o_valid        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grantIdx     = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// uart_tx_arbiter : round-robin sharing of one UART transmitter with watchdog
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
    import uart_defs::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int clksPerBit   = 234,
    parameter int frameBits    = FRAME_BITS_DEFAULT,
    parameter int TIMEOUT_CLKS = 2 * clksPerBit * frameBits
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [8*NUM_REQ-1:0]       i_reqData,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic                       o_txStart,
    output logic [7:0]                 o_txData,
    input  logic                       i_txFinished,
    output logic [clog2(NUM_REQ)-1:0]  o_grantId,
    output logic                       o_busy,
    output logic                       o_timeout,
    output logic [15:0]                o_frameCount
);

    localparam int ID_W = clog2(NUM_REQ);
    localparam int WD_W = (TIMEOUT_CLKS > 1) ? clog2(TIMEOUT_CLKS) : 1;
    localparam logic [WD_W-1:0] c_WD_LAST = WD_W'(TIMEOUT_CLKS - 1);
    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

    txState_t           r_state;
    logic [ID_W-1:0]    r_rrPtr;
    logic [WD_W-1:0]    r_watchdog;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_txStart;
    logic [7:0]         r_txData;
    logic [ID_W-1:0]    r_grantId;
    logic               r_busy;
    logic               r_timeout;
    logic [15:0]        r_frameCount;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grantIdx;
    logic               w_grantValid;
    logic [7:0]         w_grantData;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req      (i_req),
        .i_rrPtr    (r_rrPtr),
        .o_grant    (w_grant),
        .o_grantIdx (w_grantIdx),
        .o_valid    (w_grantValid)
    );

    always_comb begin
        w_grantData = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grantIdx == ID_W'(k)) begin
                w_grantData = i_reqData[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_rrPtr      <= '0;
            r_watchdog   <= '0;
            r_ack        <= '0;
            r_txStart    <= 1'b0;
            r_txData     <= '0;
            r_grantId    <= '0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
            r_frameCount <= '0;
        end else begin
            r_ack     <= '0;
            r_txStart <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grantValid) begin
                        r_state   <= START;
                        r_ack     <= w_grant;
                        r_txStart <= 1'b1;
                        r_txData  <= w_grantData;
                        r_grantId <= w_grantIdx;
                        r_rrPtr   <= (w_grantIdx == c_LAST_ID) ? '0 : w_grantIdx + ID_W'(1);
                        r_busy    <= 1'b1;
                    end
                end
                START: begin
                    r_state    <= WAIT;
                    r_watchdog <= '0;
                end
                WAIT: begin
                    // A done pulse on the abort cycle still counts as a completed frame
                    if (i_txFinished) begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_frameCount <= r_frameCount + 16'd1;
                    end else if (r_watchdog == c_WD_LAST) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_watchdog <= r_watchdog + WD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ack        = r_ack;
    assign o_txStart    = r_txStart;
    assign o_txData     = r_txData;
    assign o_grantId    = r_grantId;
    assign o_busy       = r_busy;
    assign o_timeout    = r_timeout;
    assign o_frameCount = r_frameCount;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// tb_uart_tx_arbiter : scenario bench with a stub transmitter and round-robin model
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NREQ      = 4;
    localparam int TMO       = 88;
    localparam int FIN_DELAY = 44;

    logic        tb_clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [7:0]  dataB [4];
    logic [31:0] reqData;
    logic        stubFin = 1'b0;
    logic        manualFin = 1'b0;
    logic        stubEn = 1'b1;
    logic        txFinished;

    logic [3:0]  ack;
    logic        txStart;
    logic [7:0]  txData;
    logic [1:0]  grantId;
    logic        busy;
    logic        timeout;
    logic [15:0] frameCount;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lastFinCyc = -100;
    int modelPtr = 0;
    int modelCount = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NREQ),
        .clksPerBit   (4),
        .frameBits    (11),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_clk        (tb_clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_reqData    (reqData),
        .o_ack        (ack),
        .o_txStart    (txStart),
        .o_txData     (txData),
        .i_txFinished (txFinished),
        .o_grantId    (grantId),
        .o_busy       (busy),
        .o_timeout    (timeout),
        .o_frameCount (frameCount)
    );

    always #5 tb_clk = ~tb_clk;
    always @(posedge tb_clk) cyc <= cyc + 1;

    assign reqData    = {dataB[3], dataB[2], dataB[1], dataB[0]};
    assign txFinished = stubFin | manualFin;

    // Stub transmitter: done pulse FIN_DELAY cycles after each start pulse
    initial begin : stubTx
        int cnt;
        cnt = 0;
        forever begin
            @(posedge tb_clk);
            #1;
            stubFin = 1'b0;
            if (!stubEn || rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt = cnt - 1;
                    if (cnt == 0) stubFin = 1'b1;
                end
                if (txStart) cnt = FIN_DELAY;
            end
        end
    end

    // Reference: first requesting index scanning upward from ptr, wrapping
    function automatic int modelPick(input logic [3:0] r, input int ptr);
        for (int off = 0; off < NREQ; off++) begin
            if (((r >> ((ptr + off) % NREQ)) & 4'd1) != 4'd0) return (ptr + off) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge tb_clk);
        #2;
        if (txFinished) lastFinCyc = cyc;
    endtask

    task automatic waitStart(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (txStart) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic waitIdle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        total++; if (ack !== 4'd0)         begin bad++; $display("FAIL reset_ack got=%b want=0000", ack); end
        total++; if (txStart !== 1'b0)     begin bad++; $display("FAIL reset_txStart got=%b want=0", txStart); end
        total++; if (txData !== 8'd0)      begin bad++; $display("FAIL reset_txData got=%h want=00", txData); end
        total++; if (grantId !== 2'd0)     begin bad++; $display("FAIL reset_grantId got=%0d want=0", grantId); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (timeout !== 1'b0)     begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
        total++; if (frameCount !== 16'd0) begin bad++; $display("FAIL reset_frameCount got=%0d want=0", frameCount); end
        rst = 1'b0;
        modelPtr = 0;
        modelCount = 0;
    endtask

    task automatic test_single();
        bit ok;
        dataB[2] = 8'h5A;
        req = 4'b0100;
        tick();
        total++; if (ack !== 4'b0100)  begin bad++; $display("FAIL single_ack got=%b want=0100", ack); end
        total++; if (txStart !== 1'b1) begin bad++; $display("FAIL single_txStart got=%b want=1", txStart); end
        total++; if (txData !== 8'h5A) begin bad++; $display("FAIL single_txData got=%h want=5a", txData); end
        total++; if (grantId !== 2'd2) begin bad++; $display("FAIL single_grantId got=%0d want=2", grantId); end
        total++; if (busy !== 1'b1)    begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        modelPtr = 3;
        req = '0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (txFinished) ok = 1'b1;
        end
        total++; if (!ok || busy !== 1'b1) begin bad++; $display("FAIL single_busy_at_done got=%b/%b want=1/1", ok, busy); end
        tick();
        modelCount++;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after_done got=%b want=0", busy); end
        total++; if (frameCount !== 16'(modelCount)) begin bad++; $display("FAIL single_frameCount got=%0d want=%0d", frameCount, modelCount); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelPtr = 0;
        modelCount = 0;
        dataB[0] = 8'h11; dataB[1] = 8'h22; dataB[2] = 8'h33; dataB[3] = 8'h44;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp = modelPick(req, modelPtr);
            waitStart(200, ok);
            total++;
            if (!ok || grantId !== 2'(exp) || txData !== dataB[exp] || ack !== 4'(1 << exp)) begin
                bad++;
                $display("FAIL rr_grant n=%0d got id=%0d data=%h ack=%b want id=%0d data=%h", n, grantId, txData, ack, exp, dataB[exp]);
            end
            if (n > 0) begin
                total++;
                if (cyc != lastFinCyc + 2) begin bad++; $display("FAIL rr_gap n=%0d got=%0d want=2", n, cyc - lastFinCyc); end
            end
            modelPtr = (exp + 1) % NREQ;
            modelCount++;
        end
        req = '0;
        waitIdle(200, ok);
        total++; if (!ok || frameCount !== 16'(modelCount)) begin bad++; $display("FAIL rr_frameCount got=%0d want=%0d", frameCount, modelCount); end
    endtask

    task automatic test_fairness();
        bit ok;
        int exp;
        int prev;
        req = 4'b0100;
        exp = modelPick(req, modelPtr);
        waitStart(50, ok);
        modelPtr = (exp + 1) % NREQ;
        modelCount++;
        req = '0;
        waitIdle(200, ok);
        prev = -1;
        req = 4'b1001;
        for (int n = 0; n < 2; n++) begin
            exp = modelPick(req, modelPtr);
            waitStart(200, ok);
            total++;
            if (!ok || grantId !== 2'(exp) || int'(grantId) == prev) begin
                bad++;
                $display("FAIL fair_grant n=%0d got=%0d want=%0d prev=%0d", n, grantId, exp, prev);
            end
            prev = int'(grantId);
            modelPtr = (exp + 1) % NREQ;
            modelCount++;
        end
        req = '0;
        waitIdle(200, ok);
    endtask

    task automatic test_random();
        bit ok;
        int exp;
        for (int n = 0; n < 12; n++) begin
            req = 4'($urandom_range(1, 15));
            for (int k = 0; k < NREQ; k++) dataB[k] = 8'($urandom);
            exp = modelPick(req, modelPtr);
            waitStart(200, ok);
            total++;
            if (!ok || grantId !== 2'(exp) || txData !== dataB[exp] || ack !== 4'(1 << exp)) begin
                bad++;
                $display("FAIL rand_grant n=%0d req=%b got id=%0d data=%h ack=%b want id=%0d data=%h", n, req, grantId, txData, ack, exp, dataB[exp]);
            end
            modelPtr = (exp + 1) % NREQ;
            modelCount++;
        end
        req = '0;
        waitIdle(200, ok);
        total++; if (!ok || frameCount !== 16'(modelCount)) begin bad++; $display("FAIL rand_frameCount got=%0d want=%0d", frameCount, modelCount); end
    endtask

    task automatic test_timeout();
        bit ok;
        int s;
        int tcyc;
        int exp;
        stubEn = 1'b0;
        req = 4'b0010;
        exp = modelPick(req, modelPtr);
        waitStart(50, ok);
        total++; if (!ok || grantId !== 2'(exp)) begin bad++; $display("FAIL tmo_first_grant got=%0d want=%0d", grantId, exp); end
        s = cyc;
        modelPtr = (exp + 1) % NREQ;
        req = 4'b1000;
        tcyc = -1;
        for (int i = 0; i < 200 && tcyc < 0; i++) begin
            tick();
            if (timeout) tcyc = cyc;
        end
        total++; if (tcyc != s + 1 + TMO) begin bad++; $display("FAIL tmo_cycle got=%0d want=%0d", tcyc - s - 1, TMO); end
        total++; if (frameCount !== 16'(modelCount)) begin bad++; $display("FAIL tmo_frameCount got=%0d want=%0d", frameCount, modelCount); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b want=0", busy); end
        stubEn = 1'b1;
        exp = modelPick(req, modelPtr);
        waitStart(10, ok);
        total++;
        if (!ok || grantId !== 2'(exp) || txData !== dataB[exp] || timeout !== 1'b0) begin
            bad++;
            $display("FAIL tmo_pending got id=%0d data=%h tmo=%b want id=%0d data=%h tmo=0", grantId, txData, timeout, exp, dataB[exp]);
        end
        modelPtr = (exp + 1) % NREQ;
        modelCount++;
        req = '0;
        waitIdle(200, ok);
        total++; if (!ok || frameCount !== 16'(modelCount)) begin bad++; $display("FAIL tmo_after_frameCount got=%0d want=%0d", frameCount, modelCount); end
    endtask

    task automatic test_finish_on_timeout();
        bit ok;
        int s;
        int exp;
        stubEn = 1'b0;
        req = 4'b0001;
        exp = modelPick(req, modelPtr);
        waitStart(50, ok);
        s = cyc;
        modelPtr = (exp + 1) % NREQ;
        req = '0;
        for (int i = 0; i < 200 && cyc < s + TMO; i++) tick();
        manualFin = 1'b1;
        tick();
        manualFin = 1'b0;
        modelCount++;
        total++; if (frameCount !== 16'(modelCount)) begin bad++; $display("FAIL edge_frameCount got=%0d want=%0d", frameCount, modelCount); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL edge_timeout got=%b want=0", timeout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL edge_busy got=%b want=0", busy); end
        tick();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL edge_timeout_late got=%b want=0", timeout); end
        manualFin = 1'b1;
        tick();
        manualFin = 1'b0;
        tick();
        total++; if (frameCount !== 16'(modelCount) || busy !== 1'b0) begin bad++; $display("FAIL stray_done got count=%0d busy=%b want count=%0d busy=0", frameCount, busy, modelCount); end
        stubEn = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int exp;
        req = 4'b0100;
        waitStart(50, ok);
        req = '0;
        for (int i = 0; i < 10; i++) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midwait_busy got=%b want=1", busy); end
        rst = 1'b1;
        req = 4'b1010;
        tick();
        total++;
        if (ack !== 4'd0 || txStart !== 1'b0 || txData !== 8'd0 || grantId !== 2'd0 ||
            busy !== 1'b0 || timeout !== 1'b0 || frameCount !== 16'd0) begin
            bad++;
            $display("FAIL midwait_reset got ack=%b st=%b d=%h id=%0d busy=%b tmo=%b cnt=%0d want all 0",
                     ack, txStart, txData, grantId, busy, timeout, frameCount);
        end
        rst = 1'b0;
        modelPtr = 0;
        modelCount = 0;
        exp = modelPick(req, modelPtr);
        waitStart(5, ok);
        total++; if (!ok || grantId !== 2'(exp) || ack !== 4'(1 << exp)) begin bad++; $display("FAIL post_reset_grant got id=%0d ack=%b want id=%0d", grantId, ack, exp); end
        modelPtr = (exp + 1) % NREQ;
        modelCount++;
        req = '0;
        waitIdle(200, ok);
        total++; if (!ok || frameCount !== 16'(modelCount)) begin bad++; $display("FAIL post_reset_frameCount got=%0d want=%0d", frameCount, modelCount); end
    endtask

    initial begin
        for (int k = 0; k < NREQ; k++) dataB[k] = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_random();
        test_timeout();
        test_finish_on_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
